// File: rtl/regdst_pipe.sv
// Write-back destination select plus a STAGES-deep destination/write-enable
// pipeline with stall, flush and per-stage RAW hazard flags for decode sources.
module regdst_pipe #(
  parameter int AW      = 5,
  parameter int STAGES  = 3,
  parameter int RA_ADDR = 31
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [AW-1:0]        rt_i,
  input  logic [AW-1:0]        rd_i,
  input  logic [1:0]           reg_dst,
  input  logic                 reg_write_i,
  input  logic                 in_valid,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [AW-1:0]        src_a,
  input  logic [AW-1:0]        src_b,
  output logic [AW-1:0]        rw,
  output logic [STAGES*AW-1:0] dest_stage,
  output logic [STAGES-1:0]    we_stage,
  output logic [STAGES-1:0]    hazard_a,
  output logic [STAGES-1:0]    hazard_b,
  output logic [AW-1:0]        wb_addr,
  output logic                 wb_en
);

  logic [AW-1:0]     dest_q [STAGES];
  logic [STAGES-1:0] we_q;
  logic              nwe;

  always_comb begin
    rw = rt_i;
    case (reg_dst)
      2'b01:   rw = rd_i;
      2'b10:   rw = AW'(RA_ADDR);
      default: rw = rt_i;
    endcase
  end

  assign nwe = in_valid & reg_write_i & (reg_dst != 2'b11) & (rw != '0);

  // Stage 0 captures a masked destination so dest is 0 whenever we is 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) dest_q[k] <= '0;
      we_q <= '0;
    end else begin
      if (flush) begin
        dest_q[0] <= '0;
        we_q[0]   <= 1'b0;
        dest_q[1] <= '0;
        we_q[1]   <= 1'b0;
      end else if (stall) begin
        dest_q[1] <= '0;
        we_q[1]   <= 1'b0;
      end else begin
        dest_q[0] <= nwe ? rw : '0;
        we_q[0]   <= nwe;
        dest_q[1] <= dest_q[0];
        we_q[1]   <= we_q[0];
      end
      for (int k = 2; k < STAGES; k++) begin
        dest_q[k] <= dest_q[k-1];
        we_q[k]   <= we_q[k-1];
      end
    end
  end

  always_comb begin
    dest_stage = '0;
    hazard_a   = '0;
    hazard_b   = '0;
    for (int k = 0; k < STAGES; k++) begin
      dest_stage[k*AW +: AW] = dest_q[k];
      hazard_a[k] = we_q[k] & (dest_q[k] == src_a) & (src_a != '0);
      hazard_b[k] = we_q[k] & (dest_q[k] == src_b) & (src_b != '0);
    end
  end

  assign we_stage = we_q;
  assign wb_addr  = dest_q[STAGES-1];
  assign wb_en    = we_q[STAGES-1];

endmodule

// File: tb/tb_regdst_pipe.sv
// Directed and random stimulus for regdst_pipe against a queue-based model
// of the in-flight destinations.
module tb_regdst_pipe;
  localparam int AW     = 5;
  localparam int STAGES = 3;
  localparam int RA     = 31;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [AW-1:0]        rt_i, rd_i, src_a, src_b;
  logic [1:0]           reg_dst;
  logic                 reg_write_i, in_valid, stall, flush;
  logic [AW-1:0]        rw;
  logic [STAGES*AW-1:0] dest_stage;
  logic [STAGES-1:0]    we_stage, hazard_a, hazard_b;
  logic [AW-1:0]        wb_addr;
  logic                 wb_en;

  always #5 clk = ~clk;

  regdst_pipe #(.AW(AW), .STAGES(STAGES), .RA_ADDR(RA)) dut (
    .clk(clk), .rst_n(rst_n), .rt_i(rt_i), .rd_i(rd_i), .reg_dst(reg_dst),
    .reg_write_i(reg_write_i), .in_valid(in_valid), .stall(stall), .flush(flush),
    .src_a(src_a), .src_b(src_b), .rw(rw), .dest_stage(dest_stage),
    .we_stage(we_stage), .hazard_a(hazard_a), .hazard_b(hazard_b),
    .wb_addr(wb_addr), .wb_en(wb_en)
  );

  typedef struct packed {
    logic [AW-1:0] d;
    logic          w;
  } ent_t;

  ent_t m_q[$];   // index 0 = stage 0
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic logic [AW-1:0] ref_rw();
    case (reg_dst)
      2'd1:    return rd_i;
      2'd2:    return AW'(RA);
      default: return rt_i;
    endcase
  endfunction

  task automatic model_reset();
    m_q.delete();
    for (int k = 0; k < STAGES; k++) m_q.push_back('0);
  endtask

  task automatic model_edge();
    logic [AW-1:0] a;
    logic          w;
    ent_t          e;
    a = ref_rw();
    w = in_valid && reg_write_i && (reg_dst != 2'd3) && (a != 0);
    e.d = w ? a : '0;
    e.w = w;
    if (flush) begin
      m_q[0] = '0;
      m_q.insert(1, '0);
    end else if (stall) begin
      m_q.insert(1, '0);
    end else begin
      m_q.push_front(e);
    end
    void'(m_q.pop_back());
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [STAGES*AW-1:0] ed;
    logic [STAGES-1:0]    ew, ha, hb;
    for (int k = 0; k < STAGES; k++) begin
      ed[k*AW +: AW] = m_q[k].d;
      ew[k] = m_q[k].w;
      ha[k] = m_q[k].w && (m_q[k].d == src_a) && (src_a != 0);
      hb[k] = m_q[k].w && (m_q[k].d == src_b) && (src_b != 0);
    end
    chk({tag, ":rw"}, rw, ref_rw());
    chk({tag, ":dest_stage"}, dest_stage, ed);
    chk({tag, ":we_stage"}, we_stage, ew);
    chk({tag, ":hazard_a"}, hazard_a, ha);
    chk({tag, ":hazard_b"}, hazard_b, hb);
    chk({tag, ":wb_addr"}, wb_addr, m_q[STAGES-1].d);
    chk({tag, ":wb_en"}, wb_en, m_q[STAGES-1].w);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    in_valid = 0; reg_write_i = 0; stall = 0; flush = 0; reg_dst = 0;
    rt_i = 0; rd_i = 0; src_a = 0; src_b = 0;
  endtask

  task automatic issue(input logic [1:0] mode, input logic [AW-1:0] rt, input logic [AW-1:0] rd);
    in_valid = 1; reg_write_i = 1; reg_dst = mode; rt_i = rt; rd_i = rd;
  endtask

  initial begin
    logic [AW-1:0] mode_exp [4];
    mode_exp[0] = 8; mode_exp[1] = 9; mode_exp[2] = AW'(RA); mode_exp[3] = 8;

    // Reset, then idle
    idle();
    rst_n = 0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1;
    for (int i = 0; i < 5; i++) step("idle");
    chk("idle_wb_en", wb_en, 0);
    chk("idle_wb_addr", wb_addr, 0);

    // Mode select
    for (int m = 0; m < 4; m++) begin
      issue(2'(m), 8, 9);
      #1;
      chk("mode_rw", rw, mode_exp[m]);
      step("mode");
    end
    idle();
    for (int i = 0; i < STAGES - 1; i++) step("mode_drain");
    chk("mode11_wb_en", wb_en, 0);
    step("mode_drain");

    // Latency of a rd=12 write
    issue(2'd1, 0, 12);
    step("lat");
    idle();
    src_a = 12;
    #1;
    chk("lat_we0", we_stage[0], 1);
    chk("lat_haz_a0", hazard_a[0], 1);
    step("lat");
    chk("lat_wb_early", wb_en, 0);
    step("lat");
    chk("lat_wb_en", wb_en, 1);
    chk("lat_wb_addr", wb_addr, 12);

    // Register 0 suppression
    issue(2'd1, 0, 0);
    src_a = 0;
    step("zero");
    chk("zero_we0", we_stage[0], 0);
    chk("zero_haz_a", hazard_a, 0);

    // Stall holds stage 0 and injects bubbles; flush+stall empties stages 0/1
    issue(2'd1, 0, 5);
    step("stall_load");
    stall = 1;
    rd_i = 20;
    step("stall");
    step("stall");
    chk("stall_s0", dest_stage[AW-1:0], 5);
    chk("stall_we1", we_stage[1], 0);
    flush = 1;
    reg_dst = 0;
    rt_i = 7;
    step("flush");
    chk("flush_we01", we_stage[1:0], 0);
    idle();

    // Asynchronous reset mid-flight
    for (int i = 1; i <= 3; i++) begin
      issue(2'd1, 0, AW'(i));
      step("inflight");
    end
    idle();
    #2;
    rst_n = 0;
    model_reset();
    #1;
    check_all("async_rst");
    chk("async_we", we_stage, 0);
    chk("async_wb_en", wb_en, 0);
    #1;
    rst_n = 1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid    = $urandom_range(0, 3) != 0;
      reg_write_i = $urandom_range(0, 3) != 0;
      reg_dst     = 2'($urandom_range(0, 3));
      rt_i        = ($urandom_range(0, 9) == 0) ? AW'(RA) : AW'($urandom_range(0, 7));
      rd_i        = AW'($urandom_range(0, 7));
      src_a       = ($urandom_range(0, 9) == 0) ? AW'(RA) : AW'($urandom_range(0, 7));
      src_b       = AW'($urandom_range(0, 7));
      stall       = $urandom_range(0, 4) == 0;
      flush       = $urandom_range(0, 7) == 0;
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/regdst_pipe.md
Name: regdst_pipe

Overview:
- Parametrised successor to the single-cycle write-register destination mux.
- Selects the write-back register address from rt, rd or the link register, based on a 2-bit mode. Drops writes to register 0.
- Carries the address and its write-enable through a STAGES-deep pipeline with stall and flush.
- Exposes every in-flight destination and per-stage RAW hazard flags for decode-stage source registers. Sits between decode and the register file write port.

Parameters:
AW, 5, register address width
STAGES, 3, pipeline depth from decode to write-back (legal 2..8)
RA_ADDR, 31, link register address used for jal/jalr/bgezal

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
rt_i  in  AW  rt field of decoded instruction
rd_i  in  AW  rd field of decoded instruction
reg_dst  in  2  00 = rt, 01 = rd, 10 = RA_ADDR, 11 = rt with write suppressed
reg_write_i  in  1  instruction writes a register
in_valid  in  1  decode slot holds a real instruction
stall  in  1  hold decode and stage 0; insert bubble into stage 1
flush  in  1  kill decode entry and stage 0 (branch/exception)
src_a  in  AW  decode-stage rs for hazard compare
src_b  in  AW  decode-stage rt for hazard compare
rw  out  AW  combinational selected destination for the current decode entry
dest_stage  out  STAGES*AW  registered destination per stage; stage k at bits [k*AW +: AW]
we_stage  out  STAGES  registered write-enable per stage
hazard_a  out  STAGES  stage k writes src_a
hazard_b  out  STAGES  stage k writes src_b
wb_addr  out  AW  dest_stage of stage STAGES-1
wb_en  out  1  we_stage of stage STAGES-1

Behaviour:
- rw is combinational and independent of clock and reset: 00→rt_i, 01→rd_i, 10→RA_ADDR, 11→rt_i.
- Qualified write-enable for the decode entry: nwe = in_valid & reg_write_i & (reg_dst != 11) & (rw != 0).
- Reset (rst_n low, asynchronous): all dest_stage fields = 0, all we_stage = 0.
  - Hence wb_en = 0, wb_addr = 0, hazard_a = hazard_b = 0.
  - Release is synchronous to the next clk edge; the first capture occurs on the first rising edge with rst_n high.
- Per rising edge, in priority order:
  - flush = 1: stage 0 ← {0, we = 0}. Stage 1 ← {0, we = 0}. Stages k ≥ 2 ← stage k-1. flush overrides stall.
  - stall = 1 (flush = 0): stage 0 holds its value. Stage 1 ← bubble {0, 0}. Stages k ≥ 2 ← stage k-1.
  - Otherwise: stage 0 ← {rw, nwe}; stage k ← stage k-1 for k ≥ 1.
- Latency: a non-stalled decode entry appears at stage 0 one edge after capture and at wb_addr/wb_en after STAGES edges.
- A bubble always has dest = 0 and we = 0. Downstream may rely on dest = 0 whenever we = 0.
- Hazard flags are combinational from registered state and the current src inputs:
  - hazard_a[k] = we_stage[k] & (dest_stage[k] == src_a) & (src_a != 0).
  - hazard_b is the same, using src_b.
  - Multiple stages may flag simultaneously. No priority encoding is applied; the consumer picks the youngest.
- Register 0: never marked as written, never flags a hazard, even when src equals 0 and dest equals 0.
- Reset asserted mid-operation clears all stages immediately. In-flight writes are lost, and wb_en drops in the same cycle without waiting for an edge.
- stall held for N edges: stage 0 is unchanged across all N edges; N bubbles enter stage 1.
- Changing inputs during stall has no effect on state.

Test Plan:
- Reset then idle: rst_n = 0, then 1 with in_valid = 0 for 5 edges → wb_en = 0, wb_addr = 0, all hazards 0.
- Mode select: rt_i = 8, rd_i = 9. reg_dst = 00/01/10/11 → rw = 8/9/31/8. For mode 11, wb_en = 0 after STAGES edges.
- Latency: issue rd = 12 write at edge 0 with STAGES = 3 → wb_en = 1 and wb_addr = 12 after edge 3 only; hazard_a[0] = 1 when src_a = 12 after edge 1.
- $0 suppression: rd_i = 0, reg_dst = 01, reg_write_i = 1 → we_stage[0] = 0 and hazard_a = 0 with src_a = 0.
- Stall/flush: stage 0 holds rd = 5 and stall = 1 for 2 edges → stage 0 stays 5, stage 1 shows 2 bubbles. flush + stall together with rt = 7 at input → stages 0 and 1 empty, stage 2 advances.
- Async reset mid-flight: three writes in flight, then pulse rst_n low between edges → we_stage = 000 and wb_en = 0 before the next edge.
